// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control decoder with an iterative unsigned MUL/DIV unit.
// Decode is zero-latency; MUL/DIV stall the pipeline for WIDTH+1 cycles.
//
// state | meaning
// IDLE  | no MUL/DIV in flight; a valid MUL/DIV issues here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result register just loaded; done pulse, stall released
module alu_ctrl_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [1:0]       ALUOp_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   output logic [2:0]       ALUCtrl_o,
   output logic             stall_o,
   output logic             mdu_done_o,
   output logic [WIDTH-1:0] mdu_result_o
);

   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_DIV = 6'b011010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_d;

   logic             is_mc;
   logic             start;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic             rem_geq;

   always_comb begin
      ALUCtrl_o = 3'b010;
      case (ALUOp_i)
         2'b00: ALUCtrl_o = 3'b010;
         2'b01: ALUCtrl_o = 3'b110;
         2'b10: ALUCtrl_o = 3'b001;
         default: begin
            case (funct_i)
               6'b100000: ALUCtrl_o = 3'b010;
               6'b100010: ALUCtrl_o = 3'b110;
               6'b100100: ALUCtrl_o = 3'b000;
               6'b100101: ALUCtrl_o = 3'b001;
               6'b101010: ALUCtrl_o = 3'b111;
               FUNCT_MUL: ALUCtrl_o = 3'b011;
               FUNCT_DIV: ALUCtrl_o = 3'b100;
               default:   ALUCtrl_o = 3'b010;
            endcase
         end
      endcase
   end

   assign is_mc = (ALUOp_i == 2'b11) && ((funct_i == FUNCT_MUL) || (funct_i == FUNCT_DIV));
   assign start = (state_q == IDLE) && valid_i && is_mc && !flush_i;

   // Remainder lives in acc, quotient bits shift into a as dividend bits shift out.
   assign rem_sh   = {acc_q, a_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, b_q};
   assign rem_geq  = (rem_sh >= {1'b0, b_q});

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = mdu_result_o;
      stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               stall_o = 1'b1;
               a_d     = rs_data_i;
               b_d     = rt_data_i;
               acc_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = (funct_i == FUNCT_DIV) ? DIV : MUL;
            end
         end
         MUL: begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
            if (cnt_d == '0) begin
               state_d = DONE;
               res_d   = acc_d;
            end
         end
         DIV: begin
            stall_o = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            acc_d   = rem_geq ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            a_d     = {a_q[WIDTH-2:0], rem_geq};
            if (cnt_d == '0) begin
               state_d = DONE;
               res_d   = a_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Flush aborts without publishing; stall already reflects the current state.
      if (flush_i) begin
         state_d = IDLE;
         res_d   = mdu_result_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         mdu_result_o <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         acc_q        <= acc_d;
         mdu_result_o <= res_d;
      end
   end

   assign mdu_done_o = (state_q == DONE);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized self-checking bench for alu_ctrl_seq with a plain-arithmetic reference model.
module tb_alu_ctrl_seq;

   localparam int W = 32;
   localparam logic [5:0] F_MUL = 6'b011000;
   localparam logic [5:0] F_DIV = 6'b011010;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          valid_i = 1'b0;
   logic [1:0]    ALUOp_i = 2'b00;
   logic [5:0]    funct_i = 6'b0;
   logic [W-1:0]  rs_data_i = '0;
   logic [W-1:0]  rt_data_i = '0;
   logic [2:0]    ALUCtrl_o;
   logic          stall_o;
   logic          mdu_done_o;
   logic [W-1:0]  mdu_result_o;

   int checks = 0;
   int errors = 0;

   alu_ctrl_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
      .ALUOp_i(ALUOp_i), .funct_i(funct_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .ALUCtrl_o(ALUCtrl_o), .stall_o(stall_o), .mdu_done_o(mdu_done_o),
      .mdu_result_o(mdu_result_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return 3'b010;
      if (op == 2'b01) return 3'b110;
      if (op == 2'b10) return 3'b001;
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b011000: return 3'b011;
         6'b011010: return 3'b100;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic logic [W-1:0] ref_mdu(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] p;
      if (is_div) return (b == 0) ? {W{1'b1}} : a / b;
      p = {32'b0, a} * {32'b0, b};
      return p[W-1:0];
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issues one op at the current cycle (cycle 0) holding valid until done is seen.
   task automatic run_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int done_cyc, output int stall_cyc, output logic [W-1:0] res);
      valid_i = 1'b1; ALUOp_i = 2'b11; funct_i = is_div ? F_DIV : F_MUL;
      rs_data_i = a; rt_data_i = b;
      done_cyc = -1; stall_cyc = 0; res = '0;
      #1;
      if (stall_o) stall_cyc++;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         tick();
         if (stall_o) stall_cyc++;
         if (mdu_done_o) begin
            done_cyc = c;
            res = mdu_result_o;
         end
      end
      valid_i = 1'b0; ALUOp_i = 2'b00; funct_i = 6'b0;
   endtask

   task automatic check_op(input string name, input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
      int dc, sc;
      logic [W-1:0] r, exp;
      exp = ref_mdu(is_div, a, b);
      run_op(is_div, a, b, dc, sc, r);
      checks++;
      if (dc !== 33) begin errors++; $display("FAIL %s done_cycle got %0d want 33", name, dc); end
      checks++;
      if (sc !== 33) begin errors++; $display("FAIL %s stall_cycles got %0d want 33", name, sc); end
      checks++;
      if (r !== exp) begin errors++; $display("FAIL %s result got %h want %h", name, r, exp); end
      tick();
      checks++;
      if (stall_o !== 1'b0 || mdu_done_o !== 1'b0) begin
         errors++; $display("FAIL %s after_done stall=%b done=%b want 0 0", name, stall_o, mdu_done_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) tick();
      checks++;
      if (stall_o !== 1'b0 || mdu_done_o !== 1'b0 || mdu_result_o !== '0) begin
         errors++; $display("FAIL reset stall=%b done=%b res=%h want 0 0 0", stall_o, mdu_done_o, mdu_result_o);
      end
      rst_i = 1'b1;
      tick();
   endtask

   task automatic test_decode();
      logic [5:0] fl [8];
      logic [5:0] f;
      logic [1:0] op;
      logic mc;
      fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100; fl[3] = 6'b100101;
      fl[4] = 6'b101010; fl[5] = 6'b011000; fl[6] = 6'b011010; fl[7] = 6'b000000;
      for (int i = 0; i < 8; i++) begin
         ALUOp_i = 2'b11; funct_i = fl[i];
         mc = (i == 5 || i == 6);
         valid_i = !mc;
         #1;
         checks++;
         if (ALUCtrl_o !== ref_ctrl(2'b11, fl[i]) || (!mc && stall_o !== 1'b0)) begin
            errors++; $display("FAIL decode_r funct=%b ctrl=%b stall=%b want %b 0", fl[i], ALUCtrl_o, stall_o, ref_ctrl(2'b11, fl[i]));
         end
      end
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         f = 6'($urandom);
         mc = (op == 2'b11) && (f == F_MUL || f == F_DIV);
         ALUOp_i = op; funct_i = f; valid_i = !mc;
         #1;
         checks++;
         if (ALUCtrl_o !== ref_ctrl(op, f) || (!mc && stall_o !== 1'b0)) begin
            errors++; $display("FAIL decode_rand op=%b funct=%b ctrl=%b stall=%b want %b", op, f, ALUCtrl_o, stall_o, ref_ctrl(op, f));
         end
      end
      valid_i = 1'b0; ALUOp_i = 2'b00; funct_i = 6'b0;
      tick();
   endtask

   task automatic test_directed();
      check_op("mul_7x6", 1'b0, 32'd7, 32'd6);
      check_op("mul_ffff_x2", 1'b0, 32'hFFFF_FFFF, 32'd2);
      check_op("div_100_7", 1'b1, 32'd100, 32'd7);
      check_op("div_5_0", 1'b1, 32'd5, 32'd0);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic d;
      for (int i = 0; i < 8; i++) begin
         d = 1'($urandom);
         a = $urandom;
         b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
         check_op(d ? "rand_div" : "rand_mul", d, a, b);
      end
   endtask

   task automatic test_flush();
      int dc, sc, seen;
      logic [W-1:0] r;
      check_op("mul_prior_42", 1'b0, 32'd7, 32'd6);
      valid_i = 1'b1; ALUOp_i = 2'b11; funct_i = F_DIV; flush_i = 1'b1;
      rs_data_i = 32'd9; rt_data_i = 32'd3;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle stall got %b want 0", stall_o); end
      tick();
      flush_i = 1'b0;
      for (int c = 1; c <= 5; c++) tick();
      flush_i = 1'b1;
      checks++;
      if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_cycle stall got %b want 1", stall_o); end
      tick();
      flush_i = 1'b0; valid_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (mdu_done_o || stall_o) seen++;
         if (c < 39) tick();
      end
      checks++;
      if (seen !== 0 || mdu_result_o !== 32'd42) begin
         errors++; $display("FAIL flush_abort busy_or_done=%0d res=%0d want 0 42", seen, mdu_result_o);
      end
      check_op("div_9_3_reissue", 1'b1, 32'd9, 32'd3);
      // Flush landing on the final iteration must cancel the done.
      valid_i = 1'b1; ALUOp_i = 2'b11; funct_i = F_MUL; rs_data_i = 32'd5; rt_data_i = 32'd5;
      for (int c = 1; c <= 32; c++) begin tick(); valid_i = 1'b0; end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      checks++;
      if (mdu_done_o !== 1'b0 || stall_o !== 1'b0 || mdu_result_o !== 32'd3) begin
         errors++; $display("FAIL flush_last done=%b stall=%b res=%0d want 0 0 3", mdu_done_o, stall_o, mdu_result_o);
      end
      run_op(1'b0, 32'd0, 32'd0, dc, sc, r);
      tick();
   endtask

   task automatic test_back_to_back();
      int dc1, sc1, dc2, sc2;
      logic [W-1:0] r1, r2;
      run_op(1'b0, 32'd2, 32'd3, dc1, sc1, r1);
      tick();
      checks++;
      if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_gap stall got %b want 0", stall_o); end
      run_op(1'b1, 32'd8, 32'd2, dc2, sc2, r2);
      checks++;
      if (dc1 !== 33 || dc1 + 1 + dc2 !== 67) begin
         errors++; $display("FAIL b2b_cycles got %0d %0d want 33 67", dc1, dc1 + 1 + dc2);
      end
      checks++;
      if (r1 !== 32'd6 || r2 !== 32'd4) begin
         errors++; $display("FAIL b2b_results got %0d %0d want 6 4", r1, r2);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int seen;
      valid_i = 1'b1; ALUOp_i = 2'b11; funct_i = F_MUL; rs_data_i = 32'd3; rt_data_i = 32'd3;
      for (int c = 1; c <= 10; c++) tick();
      rst_i = 1'b0; valid_i = 1'b0; ALUOp_i = 2'b00; funct_i = 6'b0;
      tick();
      checks++;
      if (stall_o !== 1'b0 || mdu_result_o !== '0 || mdu_done_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid stall=%b res=%h done=%b want 0 0 0", stall_o, mdu_result_o, mdu_done_o);
      end
      rst_i = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin tick(); if (mdu_done_o) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL reset_mid_done pulses got %0d want 0", seen); end
   endtask

   initial begin
      #1;
      test_reset();
      test_decode();
      test_directed();
      test_random();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
